// File: rtl/regfile_bus_master.sv
// Register-file bus initiator: runs one READ/WRITE/MOVE/INC command at a time
// as read and/or write cycles on the shared register-file bus.
module regfile_bus_master #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUMOF_REGS = 33
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rs,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_RegWrt,
    output logic                  bus_enReg,
    inout  wire  [DATA_WIDTH-1:0] bus_data
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_MOVE = 2'b10, OP_INC = 2'b11} op_t;

    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(NUMOF_REGS);

    state_t                state_q;
    op_t                   op_q;
    logic [ADDR_WIDTH-1:0] rs_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] t_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    op_t                   cmd_op_d;
    logic                  cmd_err_d;
    logic [DATA_WIDTH-1:0] wr_data_d;

    // Only the address fields an op actually uses are range-checked.
    always_comb begin
        cmd_op_d  = op_t'(cmd_op);
        cmd_err_d = ((cmd_op_d != OP_WRITE) && ({1'b0, cmd_rs} >= LIMIT)) ||
                    ((cmd_op_d != OP_READ)  && ({1'b0, cmd_rd} >= LIMIT));
    end

    always_comb begin
        wr_data_d = t_q + DATA_WIDTH'(1);
        unique case (op_q)
            OP_WRITE: wr_data_d = imm_q;
            OP_MOVE:  wr_data_d = t_q;
            default:  wr_data_d = t_q + DATA_WIDTH'(1);
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_READ;
            rs_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            t_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op_d;
                        rs_q  <= cmd_rs;
                        rd_q  <= cmd_rd;
                        imm_q <= cmd_imm;
                        if (cmd_err_d) begin
                            state_q     <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else if (cmd_op_d == OP_WRITE) begin
                            state_q <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    t_q <= bus_data;
                    if (op_q == OP_READ) begin
                        state_q     <= S_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus_data;
                    end else begin
                        state_q <= S_WR;
                    end
                end
                S_WR: begin
                    state_q     <= S_RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= wr_data_d;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == S_IDLE) && !reset;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;
    assign bus_enReg  = (state_q == S_RD) || (state_q == S_WR);
    assign bus_RegWrt = (state_q == S_WR);
    assign bus_addr   = (state_q == S_RD) ? rs_q : (state_q == S_WR) ? rd_q : '0;
    assign bus_data   = (state_q == S_WR) ? wr_data_d : 'z;

endmodule

// File: tb/tb_regfile_bus_master.sv
// Bench for regfile_bus_master: behavioural register file on the bus plus a
// response scoreboard checking data, error flag and accept-to-response latency.
`timescale 1ns/1ps
module tb_regfile_bus_master;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam logic [DW-1:0] KEEP = 32'h5A5A_C3C3;
    localparam logic [1:0] OP_READ = 2'b00, OP_WRITE = 2'b01, OP_MOVE = 2'b10, OP_INC = 2'b11;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rs;
    logic [AW-1:0] cmd_rd;
    logic [DW-1:0] cmd_imm;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] bus_addr;
    logic          bus_RegWrt;
    logic          bus_enReg;
    wire  [DW-1:0] bus_data;

    logic [DW-1:0] rf [0:63] = '{default: '0};
    logic [DW-1:0] slave_drv;

    int tests = 0;
    int fails = 0;
    int lat;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        longint        acc;
    } exp_t;
    exp_t sbq[$];

    always #5 clock = ~clock;

    regfile_bus_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUMOF_REGS(33)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rs     (cmd_rs),
        .cmd_rd     (cmd_rd),
        .cmd_imm    (cmd_imm),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .bus_addr   (bus_addr),
        .bus_RegWrt (bus_RegWrt),
        .bus_enReg  (bus_enReg),
        .bus_data   (bus_data)
    );

    // Register file slave; outside read cycles it drives a marker pattern so any
    // master drive outside WR shows up as a corrupted bus value.
    always_comb slave_drv = (bus_enReg && !bus_RegWrt) ? rf[bus_addr] : KEEP;
    assign bus_data = (bus_enReg && bus_RegWrt) ? {DW{1'bz}} : slave_drv;
    always @(posedge clock) if (bus_enReg && bus_RegWrt && bus_addr != 0) rf[bus_addr] <= bus_data;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (rsp_valid === 1'b1) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: rsp_valid=1 data=%h, required no response", rsp_data);
            end else begin
                e   = sbq.pop_front();
                lat = int'(($time - e.acc) / 10);
                if (rsp_data !== e.data || rsp_err !== e.err || lat != e.lat) begin
                    fails++;
                    $display("FAIL rsp: data=%h err=%b lat=%0d, required data=%h err=%b lat=%0d",
                             rsp_data, rsp_err, lat, e.data, e.err, e.lat);
                end
            end
        end
        if (!(bus_enReg === 1'b1 && bus_RegWrt === 1'b1)) begin
            tests++;
            if (bus_data !== slave_drv) begin
                fails++;
                $display("FAIL bus_contention: bus_data=%h, required %h (master high-Z)", bus_data, slave_drv);
            end
        end
        if (bus_enReg !== 1'b1) begin
            tests++;
            if (bus_addr !== '0 || bus_RegWrt !== 1'b0) begin
                fails++;
                $display("FAIL idle_bus: addr=%0d RegWrt=%b, required addr=0 RegWrt=0", bus_addr, bus_RegWrt);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rd,
                         input logic [DW-1:0] imm, input logic [DW-1:0] ed, input logic ee,
                         input int el, input bit expect_rsp, output longint acc);
        int n = 0;
        cmd_op = op; cmd_rs = rs; cmd_rd = rd; cmd_imm = imm; cmd_valid = 1'b1;
        acc = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end else begin
            acc = $time;
            if (expect_rsp) sbq.push_back('{ed, ee, el, acc});
            @(negedge clock);
        end
    endtask

    task automatic drain;
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        tests++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: cmd_ready=%b, required 0", cmd_ready); end
        tests++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== '0) begin
            fails++; $display("FAIL reset_rsp: valid=%b err=%b data=%h, required 0 0 0", rsp_valid, rsp_err, rsp_data);
        end
        tests++;
        if (bus_enReg !== 1'b0 || bus_RegWrt !== 1'b0 || bus_addr !== '0) begin
            fails++; $display("FAIL reset_bus: en=%b wrt=%b addr=%0d, required 0 0 0", bus_enReg, bus_RegWrt, bus_addr);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready); end
        @(negedge clock);
    endtask

    task automatic test_write_read;
        longint a;
        issue(OP_WRITE, 0, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, a);
        tests++;
        if (bus_enReg !== 1'b1 || bus_RegWrt !== 1'b1 || bus_addr !== 6'd5 || bus_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL wr_cycle: en=%b wrt=%b addr=%0d data=%h, required 1 1 5 deadbeef",
                              bus_enReg, bus_RegWrt, bus_addr, bus_data);
        end
        cmd_valid = 1'b0;
        drain;
        issue(OP_READ, 5, 0, '0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, a);
        tests++;
        if (bus_enReg !== 1'b1 || bus_RegWrt !== 1'b0 || bus_addr !== 6'd5) begin
            fails++; $display("FAIL rd_cycle: en=%b wrt=%b addr=%0d, required 1 0 5", bus_enReg, bus_RegWrt, bus_addr);
        end
        cmd_valid = 1'b0;
        drain;
    endtask

    task automatic test_inc_wrap;
        longint a;
        logic [DW-1:0] ev = 32'hFFFF_FFFC;
        issue(OP_WRITE, 0, 32, ev, ev, 1'b0, 2, 1'b1, a);
        cmd_valid = 1'b0;
        drain;
        for (int i = 0; i < 4; i++) begin
            ev = ev + 32'd1;
            issue(OP_INC, 32, 32, '0, ev, 1'b0, 3, 1'b1, a);
            cmd_valid = 1'b0;
            drain;
        end
    endtask

    task automatic test_move;
        longint a;
        issue(OP_WRITE, 0, 7, 32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1'b1, a);
        cmd_valid = 1'b0;
        drain;
        issue(OP_MOVE, 7, 0, '0, 32'h1234_5678, 1'b0, 3, 1'b1, a);
        cmd_valid = 1'b0;
        tests++;
        if (bus_enReg !== 1'b1 || bus_RegWrt !== 1'b0 || bus_addr !== 6'd7) begin
            fails++; $display("FAIL move_rd_cycle: en=%b wrt=%b addr=%0d, required 1 0 7", bus_enReg, bus_RegWrt, bus_addr);
        end
        @(negedge clock);
        tests++;
        if (bus_enReg !== 1'b1 || bus_RegWrt !== 1'b1 || bus_addr !== 6'd0 || bus_data !== 32'h1234_5678) begin
            fails++; $display("FAIL move_wr_cycle: en=%b wrt=%b addr=%0d data=%h, required 1 1 0 12345678",
                              bus_enReg, bus_RegWrt, bus_addr, bus_data);
        end
        drain;
        issue(OP_READ, 0, 0, '0, 32'h0, 1'b0, 2, 1'b1, a);
        cmd_valid = 1'b0;
        drain;
    endtask

    task automatic test_range_err;
        longint a;
        issue(OP_READ, 33, 0, '0, 32'h0, 1'b1, 1, 1'b1, a);
        tests++;
        if (bus_enReg !== 1'b0) begin fails++; $display("FAIL err_read_bus: en=%b, required 0", bus_enReg); end
        cmd_valid = 1'b0;
        drain;
        issue(OP_WRITE, 0, 63, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b1, a);
        tests++;
        if (bus_enReg !== 1'b0) begin fails++; $display("FAIL err_write_bus: en=%b, required 0", bus_enReg); end
        cmd_valid = 1'b0;
        drain;
        issue(OP_INC, 5, 40, '0, 32'h0, 1'b1, 1, 1'b1, a);
        cmd_valid = 1'b0;
        drain;
        issue(OP_MOVE, 5, 32, '0, 32'hDEAD_BEEF, 1'b0, 3, 1'b1, a);
        cmd_valid = 1'b0;
        drain;
        issue(OP_READ, 32, 0, '0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, a);
        cmd_valid = 1'b0;
        drain;
    endtask

    task automatic test_reset_mid_write;
        longint a;
        issue(OP_WRITE, 0, 3, 32'h1111_1111, 32'h1111_1111, 1'b0, 2, 1'b1, a);
        cmd_valid = 1'b0;
        drain;
        issue(OP_WRITE, 0, 3, 32'hA5A5_A5A5, '0, 1'b0, 0, 1'b0, a);
        tests++;
        if (bus_enReg !== 1'b1 || bus_data !== 32'hA5A5_A5A5) begin
            fails++; $display("FAIL abort_wr_cycle: en=%b data=%h, required 1 a5a5a5a5", bus_enReg, bus_data);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (bus_enReg !== 1'b0 || bus_RegWrt !== 1'b0 || cmd_ready !== 1'b0) begin
            fails++; $display("FAIL abort_immediate: en=%b wrt=%b ready=%b, required 0 0 0", bus_enReg, bus_RegWrt, cmd_ready);
        end
        cmd_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: cmd_ready=%b, required 1", cmd_ready); end
        tests++;
        if (rf[3] !== 32'h1111_1111) begin fails++; $display("FAIL abort_r3: r3=%h, required 11111111", rf[3]); end
        @(negedge clock);
        issue(OP_READ, 3, 0, '0, 32'h1111_1111, 1'b0, 2, 1'b1, a);
        cmd_valid = 1'b0;
        drain;
    endtask

    task automatic test_back_to_back;
        longint a0, a1, a2, a3, a4;
        issue(OP_READ, 5, 0, '0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, a0);
        issue(OP_WRITE, 0, 9, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2, 1'b1, a1);
        issue(OP_INC, 9, 10, '0, 32'h0BAD_F00E, 1'b0, 3, 1'b1, a2);
        issue(OP_READ, 50, 0, '0, 32'h0, 1'b1, 1, 1'b1, a3);
        issue(OP_READ, 10, 0, '0, 32'h0BAD_F00E, 1'b0, 2, 1'b1, a4);
        cmd_valid = 1'b0;
        drain;
        tests++;
        if (a1 - a0 != 30 || a2 - a1 != 30 || a3 - a2 != 40 || a4 - a3 != 20) begin
            fails++; $display("FAIL spacing: %0d %0d %0d %0d ns, required 30 30 40 20",
                              a1 - a0, a2 - a1, a3 - a2, a4 - a3);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rd = '0; cmd_imm = '0;
        test_reset;
        test_write_read;
        test_inc_wrap;
        test_move;
        test_range_err;
        test_reset_mid_write;
        test_back_to_back;
        repeat (3) @(negedge clock);
        tests++;
        if (sbq.size() != 0) begin fails++; $display("FAIL leftover: %0d responses missing, required 0", sbq.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
